// File: rtl/fpu_cmd_initiator.sv
// FPU bus-master sequencer: write A (op in address), write B, poll result, respond.
// Optional poll timeout enabled by defining FPU_INIT_TIMEOUT_EN.
module fpu_cmd_initiator #(
  parameter logic [5:0] B_ADDR         = 6'h01,
  parameter logic [5:0] RESULT_ADDR    = 6'h0C,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic [5:0]  bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_write_n,
  output logic [1:0]  bus_read_n,
  input  logic [31:0] bus_rdata,
  input  logic        bus_data_ready
);

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, POLL, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] b_q, b_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  wr_n_q, wr_n_d;
  logic [1:0]  rd_n_q, rd_n_d;
  logic        rv_q, rv_d;
  logic [15:0] rdata_q, rdata_d;

`ifdef FPU_INIT_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  logic        to_q, to_d;
  logic        unused_rdata;
  assign unused_rdata = ^bus_rdata[31:16];
`else
  logic        unused_rdata;
  assign unused_rdata = ^{bus_rdata[31:16], TIMEOUT_CYCLES};
`endif

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rv_q;
  assign rsp_data    = rdata_q;
  assign bus_address = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_write_n = wr_n_q;
  assign bus_read_n  = rd_n_q;
`ifdef FPU_INIT_TIMEOUT_EN
  assign rsp_timeout = to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Next state and next registered outputs; bus fields idle unless set.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    addr_d  = 6'h00;
    wdata_d = 32'h0;
    wr_n_d  = 2'b11;
    rd_n_d  = 2'b11;
    rv_d    = rv_q;
    rdata_d = rdata_q;
`ifdef FPU_INIT_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = WR_A;
          b_d     = cmd_b;
          addr_d  = {1'b0, cmd_op, 2'b00};
          wdata_d = {16'h0, cmd_a};
          wr_n_d  = 2'b01;
        end
      end
      WR_A: begin
        state_d = WR_B;
        addr_d  = B_ADDR;
        wdata_d = {16'h0, b_q};
        wr_n_d  = 2'b01;
      end
      WR_B: begin
        state_d = POLL;
        addr_d  = RESULT_ADDR;
        rd_n_d  = 2'b01;
`ifdef FPU_INIT_TIMEOUT_EN
        cnt_d   = 16'h0;
`endif
      end
      POLL: begin
        if (bus_data_ready) begin
          state_d = RESP;
          rv_d    = 1'b1;
          rdata_d = bus_rdata[15:0];
`ifdef FPU_INIT_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
`ifdef FPU_INIT_TIMEOUT_EN
        else if (cnt_q == TO_LIMIT) begin
          state_d = RESP;
          rv_d    = 1'b1;
          rdata_d = 16'h0;
          to_d    = 1'b1;
        end
`endif
        else begin
          addr_d  = RESULT_ADDR;
          rd_n_d  = 2'b01;
`ifdef FPU_INIT_TIMEOUT_EN
          cnt_d   = cnt_q + 16'h1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      b_q     <= 16'h0;
      addr_q  <= 6'h00;
      wdata_q <= 32'h0;
      wr_n_q  <= 2'b11;
      rd_n_q  <= 2'b11;
      rv_q    <= 1'b0;
      rdata_q <= 16'h0;
`ifdef FPU_INIT_TIMEOUT_EN
      cnt_q   <= 16'h0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
`ifdef FPU_INIT_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

endmodule
